eth_tx_scheduler: RTL and testbench

Frame-level TX controller for the RGMII Ethernet MAC, sitting between software/DMA and the MAC's 32-bit configuration REG_BUS. It queues TX frame descriptors (packet length) and programs any pending MAC-address update. For each queued frame it issues the start write and waits for the MAC's transmit-complete pulse, with a timeout. It replaces manual register pokes, so each frame is started only after the previous one finishes and the buffer is free again.

---
 rtl/eth_tx_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_eth_tx_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_scheduler.sv
// rtl/eth_tx_scheduler.sv - TX frame scheduler driving the MAC REG_BUS
// Queues frame descriptors, programs pending MAC address updates, starts frames and waits for done.
module eth_tx_scheduler #(
  parameter int          DESC_DEPTH    = 4,
  parameter int          TIMEOUT_CYC   = 65535,
  parameter logic [31:0] TX_CTRL_FLAGS = 32'h0020_5000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        desc_valid_i,
  input  logic [10:0] desc_len_i,
  output logic        desc_ready_o,
  input  logic        mac_we_i,
  input  logic [47:0] mac_addr_i,
  input  logic        tx_done_i,
  output logic [3:0]  reg_addr_o,
  output logic        reg_write_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_wstrb_o,
  output logic        reg_valid_o,
  input  logic        reg_ready_i,
  input  logic        reg_error_i,
  output logic        busy_o,
  output logic [2:0]  err_o,
  input  logic        err_clr_i,
  output logic [15:0] frames_sent_o
);

  localparam int AW = $clog2(DESC_DEPTH);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MACLO, S_WR_MACHI, S_POP, S_START, S_WAIT_DONE
  } state_t;

  state_t state, next_state;

  logic [10:0]   fifo_mem [DESC_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop, fifo_empty;
  logic [10:0]   cur_len;

  logic [47:0]   mac_shadow;
  logic          mac_pend;
  logic [TW-1:0] to_cnt;

  logic          write_state, bus_err, to_err, zero_err;
  logic          valid_d;
  logic [3:0]    addr_d;
  logic [31:0]   wdata_d;

  assign desc_ready_o = (fifo_cnt != (AW+1)'(DESC_DEPTH));
  assign fifo_empty   = (fifo_cnt == '0);
  assign push         = desc_valid_i && desc_ready_o;
  assign pop          = (state == S_POP);
  assign cur_len      = fifo_mem[rd_ptr];

  assign busy_o      = (state != S_IDLE);
  assign reg_wstrb_o = 4'b1111;

  assign write_state = (state == S_WR_MACLO) || (state == S_WR_MACHI) || (state == S_START);
  assign bus_err     = write_state && reg_ready_i && reg_error_i;
  assign to_err      = (state == S_WAIT_DONE) && !tx_done_i && (to_cnt == TO_LAST);
  assign zero_err    = (state == S_POP) && (cur_len == 11'd0);

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= desc_len_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // A new address arriving mid-update re-arms mac_pend so the full pair is rewritten.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mac_shadow <= '0;
      mac_pend   <= 1'b0;
    end else begin
      if (mac_we_i) begin
        mac_shadow <= mac_addr_i;
        mac_pend   <= 1'b1;
      end else if (state == S_WR_MACHI && reg_ready_i && !reg_error_i) begin
        mac_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt        <= '0;
      err_o         <= '0;
      frames_sent_o <= '0;
    end else begin
      if (state == S_START)          to_cnt <= '0;
      else if (state == S_WAIT_DONE) to_cnt <= to_cnt + 1'b1;
      err_o <= (err_clr_i ? 3'b000 : err_o) | {zero_err, to_err, bus_err};
      if (state == S_WAIT_DONE && tx_done_i) frames_sent_o <= frames_sent_o + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (mac_pend)         next_state = S_WR_MACLO;
        else if (!fifo_empty) next_state = S_POP;
      end
      S_WR_MACLO:  if (reg_ready_i) next_state = reg_error_i ? S_IDLE : S_WR_MACHI;
      S_WR_MACHI:  if (reg_ready_i) next_state = S_IDLE;
      S_POP:       next_state = (cur_len == 11'd0) ? S_IDLE : S_START;
      S_START:     if (reg_ready_i) next_state = reg_error_i ? S_IDLE : S_WAIT_DONE;
      S_WAIT_DONE: if (tx_done_i || to_cnt == TO_LAST) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Bus fields load only on entry to a write state so they hold until accepted.
  always_comb begin
    valid_d = 1'b0;
    addr_d  = reg_addr_o;
    wdata_d = reg_wdata_o;
    case (next_state)
      S_WR_MACLO: begin
        valid_d = 1'b1;
        if (state != S_WR_MACLO) begin
          addr_d  = 4'h0;
          wdata_d = mac_shadow[31:0];
        end
      end
      S_WR_MACHI: begin
        valid_d = 1'b1;
        if (state != S_WR_MACHI) begin
          addr_d  = 4'h4;
          wdata_d = {16'h0, mac_shadow[47:32]};
        end
      end
      S_START: begin
        valid_d = 1'b1;
        if (state != S_START) begin
          addr_d  = 4'h8;
          wdata_d = TX_CTRL_FLAGS | {21'h0, cur_len};
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
    end else begin
      reg_valid_o <= valid_d;
      reg_write_o <= valid_d;
      reg_addr_o  <= addr_d;
      reg_wdata_o <= wdata_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb/tb_eth_tx_scheduler.sv - directed self-checking bench for eth_tx_scheduler
module tb_eth_tx_scheduler;

  localparam int          TO    = 256;
  localparam logic [31:0] FLAGS = 32'h0020_5000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        desc_valid_i;
  logic [10:0] desc_len_i;
  logic        desc_ready_o;
  logic        mac_we_i;
  logic [47:0] mac_addr_i;
  logic        tx_done_i;
  logic [3:0]  reg_addr_o;
  logic        reg_write_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_valid_o;
  logic        reg_ready_i;
  logic        reg_error_i;
  logic        busy_o;
  logic [2:0]  err_o;
  logic        err_clr_i;
  logic [15:0] frames_sent_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          valid_cycles = 0;
  int          saved;
  logic [31:0] starts[$];

  eth_tx_scheduler #(.DESC_DEPTH(4), .TIMEOUT_CYC(TO), .TX_CTRL_FLAGS(FLAGS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .desc_valid_i(desc_valid_i), .desc_len_i(desc_len_i), .desc_ready_o(desc_ready_o),
    .mac_we_i(mac_we_i), .mac_addr_i(mac_addr_i), .tx_done_i(tx_done_i),
    .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_ready_i(reg_ready_i),
    .reg_error_i(reg_error_i), .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .frames_sent_o(frames_sent_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (reg_valid_o) valid_cycles++;
    if (reg_valid_o && reg_ready_i && reg_addr_o == 4'h8) starts.push_back(reg_wdata_o);
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a held descriptor is dropped once the DUT has accepted it.
  task automatic tick();
    logic acc;
    acc = desc_valid_i && desc_ready_o;
    @(posedge clk_i);
    #1;
    if (acc) desc_valid_i = 1'b0;
  endtask

  task automatic push(input logic [10:0] len);
    int k;
    desc_len_i   = len;
    desc_valid_i = 1'b1;
    k = 0;
    while (desc_valid_i && k < 50) begin
      tick();
      k++;
    end
    chk("push accepted", 48'(desc_valid_i), 48'h0);
    desc_valid_i = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k;
    k = 0;
    while (starts.size() < n && k < 600) begin
      tick();
      k++;
    end
    chk("start seen", 48'(starts.size()), 48'(n));
  endtask

  task automatic pulse_done();
    tx_done_i = 1'b1;
    tick();
    tx_done_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; desc_valid_i = 1'b0; desc_len_i = '0; mac_we_i = 1'b0; mac_addr_i = '0;
    tx_done_i = 1'b0; reg_ready_i = 1'b0; reg_error_i = 1'b0; err_clr_i = 1'b0;
    tick(); tick();

    chk("rst valid", 48'(reg_valid_o), 48'h0);
    chk("rst write", 48'(reg_write_o), 48'h0);
    chk("rst addr", 48'(reg_addr_o), 48'h0);
    chk("rst wdata", 48'(reg_wdata_o), 48'h0);
    chk("rst wstrb", 48'(reg_wstrb_o), 48'hF);
    chk("rst ready", 48'(desc_ready_o), 48'h1);
    chk("rst busy", 48'(busy_o), 48'h0);
    chk("rst err", 48'(err_o), 48'h0);
    chk("rst frames", 48'(frames_sent_o), 48'h0);
    rst_i = 1'b0;
    reg_ready_i = 1'b1;
    tick();

    // MAC address programming
    mac_we_i = 1'b1; mac_addr_i = 48'h0040_0089_0702;
    tick();
    mac_we_i = 1'b0;
    chk("mac idle", 48'(busy_o), 48'h0);
    tick();
    chk("maclo valid", 48'(reg_valid_o), 48'h1);
    chk("maclo write", 48'(reg_write_o), 48'h1);
    chk("maclo addr", 48'(reg_addr_o), 48'h0);
    chk("maclo data", 48'(reg_wdata_o), 48'h0089_0702);
    tick();
    chk("machi valid", 48'(reg_valid_o), 48'h1);
    chk("machi addr", 48'(reg_addr_o), 48'h4);
    chk("machi data", 48'(reg_wdata_o), 48'h0000_0040);
    tick();
    chk("mac done valid", 48'(reg_valid_o), 48'h0);
    tick();
    chk("mac done busy", 48'(busy_o), 48'h0);
    chk("mac no rewrite", 48'(reg_valid_o), 48'h0);

    // Single frame, push-to-START latency of 3 cycles
    starts.delete();
    push(11'd64);
    chk("sf busy0", 48'(busy_o), 48'h0);
    tick();
    chk("sf pop busy", 48'(busy_o), 48'h1);
    chk("sf pop valid", 48'(reg_valid_o), 48'h0);
    tick();
    chk("sf start valid", 48'(reg_valid_o), 48'h1);
    chk("sf start addr", 48'(reg_addr_o), 48'h8);
    chk("sf start data", 48'(reg_wdata_o), 48'h0020_5040);
    tick();
    chk("sf wait valid", 48'(reg_valid_o), 48'h0);
    repeat (197) tick();
    chk("sf still busy", 48'(busy_o), 48'h1);
    pulse_done();
    chk("sf frames", 48'(frames_sent_o), 48'h1);
    chk("sf busy", 48'(busy_o), 48'h0);
    chk("sf one start", 48'(starts.size()), 48'h1);

    // Queue full and ordering
    starts.delete();
    for (int i = 0; i < 5; i++) push(11'(60 + i));
    chk("q full", 48'(desc_ready_o), 48'h0);
    desc_len_i = 11'd65; desc_valid_i = 1'b1;
    tick(); tick();
    chk("q full ignore", 48'(desc_valid_i), 48'h1);
    chk("q full ready", 48'(desc_ready_o), 48'h0);
    for (int i = 0; i < 6; i++) begin
      wait_starts(i + 1);
      tick(); tick();
      chk("q one start per done", 48'(starts.size()), 48'(i + 1));
      pulse_done();
    end
    chk("q 65 accepted", 48'(desc_valid_i), 48'h0);
    for (int k = 0; k < 6; k++) chk("q order", 48'(starts[k]), 48'(FLAGS | 32'(60 + k)));
    chk("q frames", 48'(frames_sent_o), 48'd7);

    // Timeout, then the next descriptor proceeds
    starts.delete();
    push(11'd100);
    push(11'd101);
    saved = 0;
    while (!reg_valid_o && saved < 50) begin tick(); saved++; end
    chk("to start data", 48'(reg_wdata_o), 48'(FLAGS | 32'd100));
    tick();
    repeat (TO - 1) tick();
    chk("to not yet", 48'(err_o), 48'h0);
    tick();
    chk("to err", 48'(err_o), 48'h2);
    chk("to busy", 48'(busy_o), 48'h0);
    chk("to frames", 48'(frames_sent_o), 48'd7);
    wait_starts(2);
    chk("to next data", 48'(starts[1]), 48'(FLAGS | 32'd101));
    pulse_done();
    chk("to next frames", 48'(frames_sent_o), 48'd8);

    // Bus error on WR_MACHI with retry
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("clr err", 48'(err_o), 48'h0);
    mac_we_i = 1'b1; mac_addr_i = 48'h1122_3344_5566;
    tick();
    mac_we_i = 1'b0;
    tick();
    chk("be lo addr", 48'(reg_addr_o), 48'h0);
    tick();
    chk("be hi addr", 48'(reg_addr_o), 48'h4);
    reg_error_i = 1'b1;
    tick();
    reg_error_i = 1'b0;
    chk("be err", 48'(err_o), 48'h1);
    chk("be valid drop", 48'(reg_valid_o), 48'h0);
    tick();
    chk("be retry valid", 48'(reg_valid_o), 48'h1);
    chk("be retry lo addr", 48'(reg_addr_o), 48'h0);
    chk("be retry lo data", 48'(reg_wdata_o), 48'h3344_5566);
    tick();
    chk("be retry hi addr", 48'(reg_addr_o), 48'h4);
    chk("be retry hi data", 48'(reg_wdata_o), 48'h0000_1122);
    tick(); tick();
    chk("be done busy", 48'(busy_o), 48'h0);

    // Zero-length descriptor
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    starts.delete();
    push(11'd0);
    repeat (4) tick();
    chk("zl err", 48'(err_o), 48'h4);
    chk("zl no start", 48'(starts.size()), 48'h0);
    chk("zl busy", 48'(busy_o), 48'h0);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("zl clr", 48'(err_o), 48'h0);

    // Reset while START is waiting with two descriptors queued
    reg_ready_i = 1'b0;
    push(11'd200);
    push(11'd201);
    push(11'd202);
    chk("rm start valid", 48'(reg_valid_o), 48'h1);
    chk("rm start data", 48'(reg_wdata_o), 48'(FLAGS | 32'd200));
    rst_i = 1'b1;
    #1;
    chk("rm valid", 48'(reg_valid_o), 48'h0);
    chk("rm write", 48'(reg_write_o), 48'h0);
    chk("rm addr", 48'(reg_addr_o), 48'h0);
    chk("rm wdata", 48'(reg_wdata_o), 48'h0);
    chk("rm busy", 48'(busy_o), 48'h0);
    chk("rm frames", 48'(frames_sent_o), 48'h0);
    chk("rm ready", 48'(desc_ready_o), 48'h1);
    tick();
    rst_i = 1'b0;
    reg_ready_i = 1'b1;
    starts.delete();
    saved = valid_cycles;
    repeat (10) tick();
    chk("rm quiet", 48'(valid_cycles), 48'(saved));
    chk("rm idle", 48'(busy_o), 48'h0);
    push(11'd50);
    wait_starts(1);
    chk("rm fresh data", 48'(starts[0]), 48'(FLAGS | 32'd50));
    pulse_done();
    chk("rm frames", 48'(frames_sent_o), 48'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
